// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: accepts parallel words over valid/ready and shifts them
// MSB-first into a programmable serial pattern detector. It counts the
// overlapping matches in each word and returns the count over a second
// valid/ready handshake.
//
// Build option: define PSC_STREAM_EN to keep the detector history and the
// fill count across words, so that matches spanning a word boundary are found.
// Without it, every accepted word starts from an empty history.
module pattern_scan_ctrl #(
  parameter int WORD_W = 16,
  parameter int PAT_W  = 8,
  parameter int CNT_W  = 5   // must satisfy 2**CNT_W > WORD_W so the count cannot wrap
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic [3:0]        cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              busy,
  output logic              bit_out,
  output logic              match,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_count,
  input  logic              res_ready
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  // Length and fill share one width, wide enough for PAT_W and for cfg_len.
  localparam int LEN_W = ($clog2(PAT_W + 1) > 4) ? $clog2(PAT_W + 1) : 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_RST  = LEN_W'(5);
  localparam logic [PAT_W-1:0] PAT_RST  = PAT_W'(8'h12);

`ifdef PSC_STREAM_EN
  localparam bit STREAM_MODE = 1'b1;
`else
  localparam bit STREAM_MODE = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q, match_d;

  logic [LEN_W-1:0]   cfg_len_c;
  logic [PAT_W-1:0]   len_mask;
  logic               scan_bit;
  logic [PAT_W-1:0]   hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic               match_c;

  // Clamp the requested length into 1..PAT_W before it is stored.
  always_comb begin
    cfg_len_c = LEN_W'(cfg_len);
    if (cfg_len == 4'd0) begin
      cfg_len_c = LEN_W'(1);
    end else if (LEN_W'(cfg_len) > LEN_MAX) begin
      cfg_len_c = LEN_MAX;
    end
  end

  // One mask bit per history position: only the newest len bits take part.
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (LEN_W'(gi) < len_q);
    end
  endgenerate

  // Detector view of the current scan cycle, evaluated on the updated history.
  always_comb begin
    scan_bit   = shreg_q[WORD_W-1];
    hist_shift = {hist_q[PAT_W-2:0], scan_bit};
    fill_inc   = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
    match_c    = (fill_inc >= len_q) &&
                 ((hist_shift & len_mask) == (pat_q & len_mask));
  end

  // Next-state logic for the IDLE -> SHIFT -> REPORT sequencer and its datapath.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Configuration is applied first, so a word accepted in the same
        // cycle is scanned with the new pattern.
        if (cfg_we) begin
          pat_d  = cfg_pat;
          len_d  = cfg_len_c;
          hist_d = '0;
          fill_d = '0;
        end
        if (in_valid) begin
          shreg_d = in_data;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
          if (!STREAM_MODE) begin
            hist_d = '0;
            fill_d = '0;
          end
        end
      end

      S_SHIFT: begin
        // Configuration writes are ignored while a word is in flight.
        hist_d  = hist_shift;
        fill_d  = fill_inc;
        shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
        idx_d   = idx_q + IDX_W'(1);
        match_d = match_c;
        if (match_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_REPORT;
        end
      end

      S_REPORT: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also restores the default pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= PAT_RST;
      len_q   <= LEN_RST;
      hist_q  <= '0;
      fill_q  <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_REPORT);
  assign res_count = cnt_q;
  assign bit_out   = hist_q[0];
  assign match     = match_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: one linear sequence of words with
// hand-computed match counts, match-pulse positions and bit order.
module tb_pattern_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [7:0]  cfg_pat;
  logic [3:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        busy;
  logic        bit_out;
  logic        match;
  logic        res_valid;
  logic [4:0]  res_count;
  logic        res_ready;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  pattern_scan_ctrl #(
    .WORD_W(16),
    .PAT_W (8),
    .CNT_W (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_pat  (cfg_pat),
    .cfg_len  (cfg_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .busy     (busy),
    .bit_out  (bit_out),
    .match    (match),
    .res_valid(res_valid),
    .res_count(res_count),
    .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one word (optionally with a same-cycle config write), follows the
  // scan and checks match positions (bit k = scan cycle k), bit order and count.
  task automatic run_word(input string tag, input logic [15:0] w,
                          input bit do_cfg, input logic [7:0] pat, input logic [3:0] len,
                          input logic [4:0] exp_cnt, input logic [15:0] exp_mvec,
                          input bit spoil, input bit hold);
    logic [15:0] mvec;
    logic [15:0] bo;
    int waited;
    mvec = '0;
    bo   = '0;
    in_data  = w;
    in_valid = 1'b1;
    cfg_we   = do_cfg;
    cfg_pat  = pat;
    cfg_len  = len;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "_accept"}, in_ready, 1);
    @(posedge clk); #1;                 // cycle T+1: scan cycle 0
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    if (hold) res_ready = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (n >= 2) begin
        mvec[n-2] = match;
        bo[17-n]  = bit_out;
      end
      if (spoil && n == 3) begin
        check({tag, "_in_ready_shift"}, in_ready, 0);
        check({tag, "_busy_shift"}, busy, 1);
        cfg_we  = 1'b1;
        cfg_pat = 8'h01;
        cfg_len = 4'd1;
      end
      if (spoil && n == 4) cfg_we = 1'b0;
      if (n == 16) check({tag, "_res_valid_early"}, res_valid, 0);
    end
    check({tag, "_res_valid"}, res_valid, 1);
    check({tag, "_count"}, res_count, exp_cnt);
    check({tag, "_match_vec"}, mvec, exp_mvec);
    check({tag, "_bit_order"}, bo, w);
    $display("word %s data=%h count=%0d match_vec=%h", tag, w, res_count, mvec);
    if (!hold) begin
      @(posedge clk); #1;
      check({tag, "_idle_ready"}, in_ready, 1);
      check({tag, "_idle_rv"}, res_valid, 0);
    end
  endtask

  initial begin
    logic [4:0]  seq_cnt;
    logic [15:0] seq_mvec;
`ifdef PSC_STREAM_EN
    seq_cnt  = 5'd1;
    seq_mvec = 16'h0001;
`else
    seq_cnt  = 5'd0;
    seq_mvec = 16'h0000;
`endif
    rst = 1'b1; cfg_we = 1'b0; cfg_pat = 8'h00; cfg_len = 4'd0;
    in_valid = 1'b0; in_data = 16'h0000; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_bit_out", bit_out, 0);
    check("rst_match", match, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_count", res_count, 0);
    $display("reset values checked");

    // Default pattern 1,0,0,1,0: overlapping hits after bits 4 and 7.
    run_word("dflt_9200", 16'h9200, 1'b0, 8'h00, 4'd0, 5'd2, 16'h0090, 1'b0, 1'b0);
    run_word("dflt_ffff", 16'hFFFF, 1'b0, 8'h00, 4'd0, 5'd0, 16'h0000, 1'b0, 1'b0);
    // Single-bit pattern '1': every set bit matches.
    run_word("len1_a5a5", 16'hA5A5, 1'b1, 8'h01, 4'd1, 5'd8, 16'hA5A5, 1'b0, 1'b0);
    // Length 0 behaves as 1.
    run_word("len0_0f01", 16'h0F01, 1'b1, 8'h01, 4'd0, 5'd5, 16'h80F0, 1'b0, 1'b0);
    // Length 15 clamps to 8 and the write lands before the same-cycle word.
    run_word("clamp_ffff", 16'hFFFF, 1'b1, 8'hFF, 4'd15, 5'd9, 16'hFF80, 1'b0, 1'b0);
    // Pattern split across a word boundary.
    run_word("seq_0009", 16'h0009, 1'b1, 8'h12, 4'd5, 5'd0, 16'h0000, 1'b0, 1'b0);
    run_word("seq_0000", 16'h0000, 1'b0, 8'h00, 4'd0, seq_cnt, seq_mvec, 1'b0, 1'b0);

    // Backpressure: cfg write during SHIFT ignored, result held for 5 cycles.
    run_word("bp1", 16'h9200, 1'b1, 8'h12, 4'd5, 5'd2, 16'h0090, 1'b1, 1'b1);
    in_data  = 16'h4800;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_rv", res_valid, 1);
      check("bp_hold_count", res_count, 2);
      check("bp_hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    check("bp_release_rv", res_valid, 1);
    check("bp_release_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("bp_idle_busy", busy, 0);
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_idle_rv", res_valid, 0);
    check("bp_idle_count", res_count, 2);
    run_word("bp2", 16'h4800, 1'b0, 8'h00, 4'd0, 5'd1, 16'h0020, 1'b0, 1'b0);

    // Reset during scan cycle 7 with a non-default pattern loaded.
    in_data = 16'h9200; in_valid = 1'b1;
    cfg_we = 1'b1; cfg_pat = 8'h01; cfg_len = 4'd1;
    check("mid_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("mid_count_before", res_count, 3);
    check("mid_match_before", match, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_bit_out", bit_out, 0);
    check("mid_rst_match", match, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_count", res_count, 0);
    $display("mid-scan reset checked");
    run_word("post_rst", 16'h9200, 1'b0, 8'h00, 4'd0, 5'd2, 16'h0090, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequencer and configuration front-end for the serial pattern detector path. It accepts parallel words over a valid/ready handshake and serialises each word MSB-first, one bit per cycle, into a programmable pattern detector. Overlapping matches are counted per word, and the count is returned over a second valid/ready handshake. It sits between the bus-side register interface and the bit-serial match logic, so software can scan whole words and retarget the pattern without touching the detector.

## Interface
- WORD_W, 16, bits per input word.
- PAT_W, 8, maximum pattern length in bits.
- CNT_W, 5, match counter width; must satisfy 2^CNT_W > WORD_W.
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high.
- cfg_we  in  1  pattern/length write strobe; honoured only in IDLE.
- cfg_pat  in  PAT_W  pattern; bit 0 is the most recently received bit.
- cfg_len  in  4  pattern length; 0 is treated as 1, and values above PAT_W are clamped to PAT_W.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when high together with in_valid.
- in_data  in  WORD_W  word to scan.
- busy  out  1  high in SHIFT and REPORT.
- bit_out  out  1  bit currently being fed to the detector (registered history LSB).
- match  out  1  registered one-cycle pulse per detected match.
- res_valid  out  1  result available.
- res_count  out  CNT_W  number of matches in the last word.
- res_ready  in  1  result consumed when high together with res_valid.

## Operation
- Reset values:
  - state is IDLE.
  - in_ready=1; busy=0; bit_out=0; match=0; res_valid=0; res_count=0.
  - Pattern register is 8'h12 with length 5, i.e. the bit sequence 1,0,0,1,0.
  - History and history fill count are 0.
- IDLE:
  - in_ready=1.
  - cfg_we latches the clamped pattern and length, and clears the history and fill count.
  - When in_valid=1, the word is loaded into the shift register, the bit index and match count are set to 0, and the state moves to SHIFT.
  - If cfg_we and in_valid are high in the same cycle, the configuration is latched first and the word is scanned with the new pattern.
- SHIFT:
  - In scan cycle k (k = 0..WORD_W-1), the scanned bit is in_data[WORD_W-1-k].
  - At the closing edge:
    - history shifts to {history[PAT_W-2:0], bit};
    - the fill count increments, saturating at PAT_W;
    - match is set to (fill count after update >= len) AND (history[len-1:0] == pat[len-1:0]);
    - when match is set, res_count increments.
  - Matches may overlap; the history is not cleared on a match.
  - After cycle WORD_W-1 the state moves to REPORT.
  - in_ready=0 and cfg_we is ignored.
- REPORT:
  - res_valid=1 and res_count is held stable.
  - When res_ready=1, the state returns to IDLE and res_valid drops at that edge.
  - in_ready=0, so a word presented during REPORT is accepted in the following IDLE cycle at the earliest.
- Width rule: the counter never wraps, because WORD_W < 2^CNT_W is a parameter legality requirement.
- Reset mid-scan or mid-report: the word and its result are abandoned, and all outputs return to their reset values the next cycle.

## Timing
- Word accepted at edge T (in_valid and in_ready both high).
- Scan cycles run T+1 .. T+WORD_W.
- match for scan cycle k is visible during cycle T+k+2. The match for the final bit is visible in the first REPORT cycle, and res_count already includes it.
- res_valid rises in cycle T+WORD_W+1.
- With res_ready held at 1, REPORT lasts one cycle.
- Minimum word-to-word interval is WORD_W+2 cycles.

## Configuration
- Macro PSC_STREAM_EN.
- Defined (stream mode): history and fill count persist across words, so patterns spanning word boundaries are detected. They are cleared only by rst or cfg_we.
- Undefined (default): history and fill count are cleared on every word acceptance, so each word is scanned independently.
- In both modes res_count covers only the bits of the current word.

## Test plan
- Defaults, word 16'h9200, res_ready=1:
  - res_count=2, from overlapping matches after scan bits 4 and 7;
  - match pulses in cycles T+6 and T+9;
  - res_valid in cycle T+17.
- Defaults, word 16'hFFFF: res_count=0 and match is never asserted.
- cfg_we with pat=8'h01 and len=1, then word 16'hA5A5: res_count=8. Then send cfg_len=0 and confirm it behaves as len=1.
- Word 16'h0009 followed by 16'h0000:
  - second word res_count=1 with PSC_STREAM_EN defined;
  - res_count=0 with it undefined;
  - first word res_count=0 in both cases.
- Backpressure: hold res_ready=0 for 5 cycles with in_valid=1. Check that res_count stays stable, in_ready=0, and the second word is accepted only after the IDLE return. Check that cfg_we pulsed during SHIFT is ignored.
- Assert rst during scan cycle 7: all outputs return to reset values and state to IDLE the next cycle, and the next word scans correctly from bit 15.
